// File: rtl/reg_file_cmd_master.sv
// Byte-stream command initiator for the register-file port: decodes write/read
// frames from the RX link, issues single-cycle accesses, and streams read data out on TX.
module reg_file_cmd_master #(
  parameter int         DATA_WIDTH = 16,
  parameter int         ADDR_WIDTH = 3,
  parameter logic [7:0] WR_CMD     = 8'hAA,
  parameter logic [7:0] RD_CMD     = 8'hBB
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            RX_DATA,
  input  logic                  RX_VALID,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  input  logic [DATA_WIDTH-1:0] RdData,
  output logic [7:0]            TX_DATA,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  output logic                  BUSY,
  output logic                  ERR
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_ISSUE,
    RD_ADDR,
    RD_ISSUE,
    RD_WAIT,
    TX_SEND
  } state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic [DATA_WIDTH-1:0]   wr_data_reg, wr_data_next;
  logic [DATA_WIDTH-1:0]   tx_shift_reg, tx_shift_next;
  logic                    err_reg, err_next;
  logic                    lane_load;

  // Each data byte lands in the lane selected by the byte counter, LS byte first.
  assign lane_load = (state_reg == WR_DATA) && RX_VALID;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
      assign wr_data_next[gi*8 +: 8] =
        (lane_load && (cnt_reg == CNT_W'(gi))) ? RX_DATA : wr_data_reg[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      addr_reg     <= '0;
      wr_data_reg  <= '0;
      tx_shift_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      addr_reg     <= addr_next;
      wr_data_reg  <= wr_data_next;
      tx_shift_reg <= tx_shift_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    addr_next     = addr_reg;
    tx_shift_next = tx_shift_reg;
    err_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (RX_VALID) begin
          if (RX_DATA == WR_CMD)      state_next = WR_ADDR;
          else if (RX_DATA == RD_CMD) state_next = RD_ADDR;
          else                        err_next   = 1'b1;
        end
      end

      WR_ADDR: begin
        if (RX_VALID) begin
          addr_next  = RX_DATA[ADDR_WIDTH-1:0];
          cnt_next   = '0;
          state_next = WR_DATA;
        end
      end

      WR_DATA: begin
        if (RX_VALID) begin
          if (cnt_reg == LAST_BYTE) begin
            cnt_next   = '0;
            state_next = WR_ISSUE;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end

      WR_ISSUE: begin
        err_next   = RX_VALID;
        state_next = IDLE;
      end

      RD_ADDR: begin
        if (RX_VALID) begin
          addr_next  = RX_DATA[ADDR_WIDTH-1:0];
          state_next = RD_ISSUE;
        end
      end

      RD_ISSUE: begin
        err_next   = RX_VALID;
        state_next = RD_WAIT;
      end

      // The file registers its output, so RdData is valid only in this cycle.
      RD_WAIT: begin
        err_next      = RX_VALID;
        tx_shift_next = RdData;
        cnt_next      = '0;
        state_next    = TX_SEND;
      end

      TX_SEND: begin
        err_next = RX_VALID;
        if (TX_READY) begin
          tx_shift_next = tx_shift_reg >> 8;
          if (cnt_reg == LAST_BYTE) begin
            cnt_next   = '0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign WrEn     = (state_reg == WR_ISSUE);
  assign RdEn     = (state_reg == RD_ISSUE);
  assign TX_VALID = (state_reg == TX_SEND);
  assign BUSY     = (state_reg != IDLE);
  assign ERR      = err_reg;
  assign Address  = addr_reg;
  assign WrData   = wr_data_reg;
  assign TX_DATA  = tx_shift_reg[7:0];

endmodule

// File: tb/tb_reg_file_cmd_master.sv
// Bench for reg_file_cmd_master: table of frames checked through an access/TX
// scoreboard, plus hand sequences for latency, backpressure, errors and reset.
module tb_reg_file_cmd_master;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic [7:0]    RX_DATA;
  logic          RX_VALID;
  logic          WrEn, RdEn;
  logic [AW-1:0] Address;
  logic [DW-1:0] WrData;
  logic [DW-1:0] RdData;
  logic [7:0]    TX_DATA;
  logic          TX_VALID;
  logic          TX_READY;
  logic          BUSY, ERR;

  always #5 CLK = ~CLK;

  reg_file_cmd_master #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .WR_CMD(8'hAA),
    .RD_CMD(8'hBB)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .RX_DATA(RX_DATA),
    .RX_VALID(RX_VALID),
    .WrEn(WrEn),
    .RdEn(RdEn),
    .Address(Address),
    .WrData(WrData),
    .RdData(RdData),
    .TX_DATA(TX_DATA),
    .TX_VALID(TX_VALID),
    .TX_READY(TX_READY),
    .BUSY(BUSY),
    .ERR(ERR)
  );

  // Register-file read model: data appears one cycle after RdEn.
  logic [DW-1:0] rd_value;
  always @(posedge CLK) if (RdEn) RdData <= rd_value;

  // kind 0 = write access {addr,data}, 1 = read access addr, 2 = TX byte
  typedef struct {
    int          kind;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int passes = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge CLK) begin
    exp_t e;
    if (RST === 1'b1) begin
      if (ERR) err_cnt++;
      if (WrEn) begin
        check("wr_rd_exclusive", {31'b0, RdEn}, 0);
        if (sb.size() == 0) check("wr_unexpected", sb.size(), 1);
        else begin
          e = sb.pop_front();
          check("wr_kind", e.kind, 0);
          check("wr_addr_data", {13'b0, Address, WrData}, e.val);
          $display("txn WR addr=%0d data=%h", Address, WrData);
        end
      end
      if (RdEn) begin
        if (sb.size() == 0) check("rd_unexpected", sb.size(), 1);
        else begin
          e = sb.pop_front();
          check("rd_kind", e.kind, 1);
          check("rd_addr", {29'b0, Address}, e.val);
          $display("txn RD addr=%0d", Address);
        end
      end
      if (TX_VALID && TX_READY) begin
        if (sb.size() == 0) check("tx_unexpected", sb.size(), 1);
        else begin
          e = sb.pop_front();
          check("tx_kind", e.kind, 2);
          check("tx_byte", {24'b0, TX_DATA}, e.val);
          $display("txn TX byte=%h", TX_DATA);
        end
      end
    end
  end

  // Called just after a rising edge; the byte is sampled on the next one.
  task automatic send(input logic [7:0] b);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    @(posedge CLK);
    #1;
    RX_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (BUSY && n < 100) begin
      @(posedge CLK);
      #1;
      n++;
    end
    check("idle_timeout", {31'b0, BUSY}, 0);
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.kind = 0; e.val = {13'b0, a, d};
    sb.push_back(e);
  endtask

  task automatic push_rd(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.kind = 1; e.val = {29'b0, a};
    sb.push_back(e);
    e.kind = 2; e.val = {24'b0, d[7:0]};
    sb.push_back(e);
    e.kind = 2; e.val = {24'b0, d[15:8]};
    sb.push_back(e);
  endtask

  typedef struct {
    bit            is_rd;
    logic [7:0]    addr_byte;
    logic [DW-1:0] data;
    logic [AW-1:0] exp_addr;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0;
    tbl[0] = '{1'b0, 8'h05, 16'h1234, 3'd5};
    tbl[1] = '{1'b1, 8'h05, 16'hBEEF, 3'd5};
    tbl[2] = '{1'b0, 8'hFF, 16'h0001, 3'd7};
    tbl[3] = '{1'b0, 8'hBB, 16'hBBAA, 3'd3};  // command bytes as payload
    tbl[4] = '{1'b1, 8'h0A, 16'h00FF, 3'd2};
    tbl[5] = '{1'b0, 8'h00, 16'hFFFF, 3'd0};
    tbl[6] = '{1'b1, 8'h77, 16'h8001, 3'd7};

    RX_DATA = 8'h00; RX_VALID = 1'b0; TX_READY = 1'b1;
    rd_value = '0; RdData = '0;
    RST = 1'b1;
    #2 RST = 1'b0;
    #3;
    check("reset_outputs", {BUSY, WrEn, RdEn, TX_VALID, ERR, Address, WrData, TX_DATA}, 0);
    #18 RST = 1'b1;
    @(posedge CLK); #1;

    // Write with exact issue timing.
    push_wr(3'd5, 16'h1234);
    send(8'hAA); send(8'h05); send(8'h34); send(8'h12);
    check("wr_issue_cycle", {30'b0, WrEn, RdEn}, 32'h2);
    check("wr_fields", {13'b0, Address, WrData}, {13'b0, 3'd5, 16'h1234});
    @(posedge CLK); #1;
    check("wr_done", {30'b0, BUSY, WrEn}, 0);

    // Table-driven frames, TX always ready.
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].is_rd) begin
        push_rd(tbl[i].exp_addr, tbl[i].data);
        rd_value = tbl[i].data;
        send(8'hBB); send(tbl[i].addr_byte);
      end else begin
        push_wr(tbl[i].exp_addr, tbl[i].data);
        send(8'hAA); send(tbl[i].addr_byte);
        send(tbl[i].data[7:0]); send(tbl[i].data[15:8]);
      end
      wait_idle();
    end

    // Illegal byte in IDLE.
    e0 = err_cnt;
    send(8'h3C);
    check("illegal_err", {30'b0, ERR, BUSY}, 32'h2);
    @(posedge CLK); #1;
    check("illegal_err_pulse", {31'b0, ERR}, 0);
    check("illegal_err_count", err_cnt - e0, 1);

    // Read latency, backpressure and a byte dropped during TX_SEND.
    TX_READY = 1'b0;
    rd_value = 16'hBEEF;
    push_rd(3'd5, 16'hBEEF);
    send(8'hBB); send(8'h05);
    check("rd_issue_cycle", {30'b0, RdEn, WrEn}, 32'h2);
    @(posedge CLK); #1;
    check("rd_wait_no_tx", {30'b0, TX_VALID, RdEn}, 0);
    @(posedge CLK); #1;
    for (int i = 0; i < 4; i++) begin
      check("bp_hold", {23'b0, TX_VALID, TX_DATA}, {23'b0, 1'b1, 8'hEF});
      if (i == 1) begin
        send(8'h3C);
        check("drop_err", {31'b0, ERR}, 1);
      end else begin
        @(posedge CLK); #1;
      end
    end
    TX_READY = 1'b1;
    @(posedge CLK); #1;
    check("bp_second_byte", {23'b0, TX_VALID, TX_DATA}, {23'b0, 1'b1, 8'hBE});
    @(posedge CLK); #1;
    check("bp_done", {30'b0, TX_VALID, BUSY}, 0);

    // Reset in the middle of a write frame.
    send(8'hAA); send(8'h02); send(8'h11);
    #2 RST = 1'b0;
    #1;
    check("rst_midwrite", {BUSY, WrEn, RdEn, TX_VALID, ERR, Address, WrData, TX_DATA}, 0);
    repeat (3) @(posedge CLK);
    #2 RST = 1'b1;
    @(posedge CLK); #1;
    push_wr(3'd2, 16'h0022);
    send(8'hAA); send(8'h02); send(8'h22); send(8'h00);
    wait_idle();

    // Reset while a TX byte is pending.
    TX_READY = 1'b0;
    rd_value = 16'h5AA5;
    push_rd(3'd1, 16'h5AA5);
    send(8'hBB); send(8'h01);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("tx_pending", {31'b0, TX_VALID}, 1);
    #2 RST = 1'b0;
    #1;
    check("rst_tx_abandon", {30'b0, TX_VALID, BUSY}, 0);
    sb.delete();
    #3 RST = 1'b1;
    TX_READY = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("post_rst_idle", {30'b0, BUSY, TX_VALID}, 0);

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
